paddle_ctrl: RTL and testbench

//   Upstream stage of the ball/collision block: produces paddle1_y/paddle2_y, the top

---
 rtl/pong_pkg.sv | 19 +
 rtl/btn_debounce.sv | 42 ++++
 rtl/paddle_ctrl.sv | 149 ++++++++++++++
 tb/tb_paddle_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared geometry for the pong datapath (paddle and ball blocks).
//   COORD_W    width of every screen / paddle coordinate
//   SCREEN_H   visible height in pixels
//   TOP_MARGIN score-bar height; paddle_y = 0 sits on this screen row
//   PADDLE_H   paddle height in pixels
//   Y_MAX      largest legal paddle top edge (paddle bottom touches screen bottom)
//   CENTER_Y   paddle rest position after reset or game over
package pong_pkg;

  localparam int COORD_W    = 10;
  localparam int SCREEN_H   = 480;
  localparam int TOP_MARGIN = 25;
  localparam int PADDLE_H   = 72;
  localparam int Y_MAX      = SCREEN_H - TOP_MARGIN - PADDLE_H;
  localparam int CENTER_Y   = Y_MAX / 2;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: conditions one raw, asynchronous push-button.
//   clk      system clock
//   reset_n  asynchronous, active-low reset
//   raw      raw button input (any timing)
//   level    debounced level; follows raw only after it has been stable
//            for 2^DB_BITS clk cycles behind a 2-flop synchronizer
module btn_debounce #(
  parameter int DB_BITS = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  logic               sync1;
  logic               sync2;
  logic [DB_BITS-1:0] cnt;

  // The counter only runs while the synchronized input disagrees with the
  // debounced level; any bounce back to agreement restarts the wait.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (&cnt) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DB_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: produces the top edge of both paddles, measured from TOP_MARGIN.
//   clk            system clock
//   reset_n        asynchronous, active-low reset (paddles recentre)
//   refresh_tick   one-clk pulse per frame; positions move only on it
//   game_active    movement enable
//   game_over      level input; recentres both paddles on a tick
//   p1_up/p1_down  raw buttons, player 1
//   p2_up/p2_down  raw buttons, player 2 (ignored while ai_enable = 1)
//   ai_enable      1 = paddle 2 tracks ball_y
//   ball_y         current ball row in screen coordinates
//   paddle1_y      paddle 1 top edge, 0..Y_MAX
//   paddle2_y      paddle 2 top edge, 0..Y_MAX
module paddle_ctrl
  import pong_pkg::*;
#(
  parameter int PADDLE_SPEED = 4,
  parameter int AI_SPEED     = 3,
  parameter int AI_DEADBAND  = 4,
  parameter int DB_BITS      = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               refresh_tick,
  input  logic               game_active,
  input  logic               game_over,
  input  logic               p1_up,
  input  logic               p1_down,
  input  logic               p2_up,
  input  logic               p2_down,
  input  logic               ai_enable,
  input  logic [COORD_W-1:0] ball_y,
  output logic [COORD_W-1:0] paddle1_y,
  output logic [COORD_W-1:0] paddle2_y
);

  // One extra bit plus sign so that y - speed and y + speed never wrap.
  localparam int EXT_W = COORD_W + 1;
  localparam logic signed [EXT_W-1:0] SPEED_S = EXT_W'(PADDLE_SPEED);
  localparam logic signed [EXT_W-1:0] Y_MAX_S = EXT_W'(Y_MAX);
  localparam logic        [EXT_W-1:0] AI_SPD_U = EXT_W'(AI_SPEED);
  localparam logic        [EXT_W-1:0] AI_DB_U  = EXT_W'(AI_DEADBAND);
  localparam coord_t                  AI_SPD_C = COORD_W'(AI_SPEED);
  localparam coord_t                  CENTER_C = COORD_W'(CENTER_Y);
  localparam coord_t                  Y_MAX_C  = COORD_W'(Y_MAX);

  // Target offset: the AI aims the paddle centre at the ball row.
  localparam int TGT_W = COORD_W + 2;
  localparam logic signed [TGT_W-1:0] TGT_OFF_S = TGT_W'(TOP_MARGIN + PADDLE_H / 2);
  localparam logic signed [TGT_W-1:0] TGT_MAX_S = TGT_W'(Y_MAX);

  logic   p1_up_lvl;
  logic   p1_down_lvl;
  logic   p2_up_lvl;
  logic   p2_down_lvl;
  coord_t ai_target;
  logic signed [TGT_W-1:0] tgt_raw;
  coord_t tgt_clamped;

  btn_debounce #(.DB_BITS(DB_BITS)) u_db_p1_up (
    .clk(clk), .reset_n(reset_n), .raw(p1_up), .level(p1_up_lvl)
  );
  btn_debounce #(.DB_BITS(DB_BITS)) u_db_p1_down (
    .clk(clk), .reset_n(reset_n), .raw(p1_down), .level(p1_down_lvl)
  );
  btn_debounce #(.DB_BITS(DB_BITS)) u_db_p2_up (
    .clk(clk), .reset_n(reset_n), .raw(p2_up), .level(p2_up_lvl)
  );
  btn_debounce #(.DB_BITS(DB_BITS)) u_db_p2_down (
    .clk(clk), .reset_n(reset_n), .raw(p2_down), .level(p2_down_lvl)
  );

  // Button-driven move with saturation at 0 and Y_MAX.
  function automatic coord_t manual_step(coord_t y, logic up, logic down);
    logic signed [EXT_W-1:0] ext;
    coord_t                  res;
    ext = signed'({1'b0, y});
    res = y;
    if (up && !down) begin
      ext = ext - SPEED_S;
      res = ext[EXT_W-1] ? '0 : ext[COORD_W-1:0];
    end else if (down && !up) begin
      ext = ext + SPEED_S;
      res = (ext > Y_MAX_S) ? Y_MAX_C : ext[COORD_W-1:0];
    end
    return res;
  endfunction

  // Tracking move: at most AI_SPEED per tick, never overshooting the target,
  // and no motion while inside the deadband.
  function automatic coord_t ai_step(coord_t y, coord_t tgt);
    logic [EXT_W-1:0] ye;
    logic [EXT_W-1:0] te;
    logic [EXT_W-1:0] diff;
    coord_t           res;
    ye   = {1'b0, y};
    te   = {1'b0, tgt};
    diff = '0;
    res  = y;
    if (te > ye + AI_DB_U) begin
      diff = te - ye;
      res  = (diff > AI_SPD_U) ? y + AI_SPD_C : tgt;
    end else if (te + AI_DB_U < ye) begin
      diff = ye - te;
      res  = (diff > AI_SPD_U) ? y - AI_SPD_C : tgt;
    end
    return res;
  endfunction

  // Ball row to paddle top edge, clamped into the legal paddle range.
  always_comb begin
    tgt_raw     = signed'({2'b00, ball_y}) - TGT_OFF_S;
    tgt_clamped = '0;
    if (tgt_raw[TGT_W-1]) begin
      tgt_clamped = '0;
    end else if (tgt_raw > TGT_MAX_S) begin
      tgt_clamped = Y_MAX_C;
    end else begin
      tgt_clamped = tgt_raw[COORD_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ai_target <= '0;
    end else begin
      ai_target <= tgt_clamped;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      paddle1_y <= CENTER_C;
      paddle2_y <= CENTER_C;
    end else if (refresh_tick) begin
      if (game_over) begin
        paddle1_y <= CENTER_C;
        paddle2_y <= CENTER_C;
      end else if (game_active) begin
        paddle1_y <= manual_step(paddle1_y, p1_up_lvl, p1_down_lvl);
        if (ai_enable) begin
          paddle2_y <= ai_step(paddle2_y, ai_target);
        end else begin
          paddle2_y <= manual_step(paddle2_y, p2_up_lvl, p2_down_lvl);
        end
      end
    end
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
module tb_paddle_ctrl;

  logic       clk;
  logic       reset_n;
  logic       refresh_tick;
  logic       game_active;
  logic       game_over;
  logic       p1_up;
  logic       p1_down;
  logic       p2_up;
  logic       p2_down;
  logic       ai_enable;
  logic [9:0] ball_y;
  logic [9:0] paddle1_y;
  logic [9:0] paddle2_y;

  int n_checks;
  int n_pass;

  paddle_ctrl #(.DB_BITS(2)) dut (
    .clk(clk), .reset_n(reset_n), .refresh_tick(refresh_tick),
    .game_active(game_active), .game_over(game_over),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .ai_enable(ai_enable), .ball_y(ball_y),
    .paddle1_y(paddle1_y), .paddle2_y(paddle2_y)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk);
    refresh_tick = 1'b1;
    @(negedge clk);
    refresh_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    p1_up = 1'b1; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b1;
    wait_clks(3);
    n_checks++;
    if (paddle1_y !== 10'd191 || paddle2_y !== 10'd191)
      $display("FAIL reset_pos: got p1=%0d p2=%0d expected 191/191", paddle1_y, paddle2_y);
    else n_pass++;
    n_checks++;
    if ({dut.u_db_p1_up.level, dut.u_db_p1_down.level,
         dut.u_db_p2_up.level, dut.u_db_p2_down.level} !== 4'b0000)
      $display("FAIL reset_levels: got %b expected 0000",
               {dut.u_db_p1_up.level, dut.u_db_p1_down.level,
                dut.u_db_p2_up.level, dut.u_db_p2_down.level});
    else n_pass++;
    p1_up = 1'b0; p2_down = 1'b0;
    reset_n = 1'b1;
    wait_clks(8);
  endtask

  task automatic test_p1_up();
    int exp;
    game_active = 1'b1;
    p1_up = 1'b1;
    wait_clks(8);
    n_checks++;
    if (dut.u_db_p1_up.level !== 1'b1)
      $display("FAIL p1_up_level: got %b expected 1", dut.u_db_p1_up.level);
    else n_pass++;
    n_checks++;
    if (paddle1_y !== 10'd191)
      $display("FAIL p1_no_move_before_tick: got %0d expected 191", paddle1_y);
    else n_pass++;
    exp = 191;
    for (int k = 1; k <= 64; k++) begin
      tick();
      exp = (exp >= 4) ? exp - 4 : 0;
      n_checks++;
      if (paddle1_y !== 10'(exp) || paddle2_y !== 10'd191)
        $display("FAIL p1_up_tick%0d: got p1=%0d p2=%0d expected %0d/191", k, paddle1_y, paddle2_y, exp);
      else n_pass++;
    end
    n_checks++;
    if (paddle1_y !== 10'd0)
      $display("FAIL p1_up_floor: got %0d expected 0", paddle1_y);
    else n_pass++;
    p1_up = 1'b0;
    wait_clks(8);
  endtask

  task automatic test_p1_down_both();
    int exp;
    p1_down = 1'b1;
    wait_clks(8);
    exp = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      exp = (exp + 4 > 383) ? 383 : exp + 4;
      n_checks++;
      if (paddle1_y !== 10'(exp))
        $display("FAIL p1_down_tick%0d: got %0d expected %0d", k, paddle1_y, exp);
      else n_pass++;
    end
    n_checks++;
    if (paddle1_y !== 10'd383)
      $display("FAIL p1_down_ceiling: got %0d expected 383", paddle1_y);
    else n_pass++;
    p1_up = 1'b1;
    wait_clks(8);
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++;
      if (paddle1_y !== 10'd383)
        $display("FAIL p1_both_hold%0d: got %0d expected 383", k, paddle1_y);
      else n_pass++;
    end
    p1_up = 1'b0; p1_down = 1'b0;
    wait_clks(8);
  endtask

  task automatic test_glitch();
    @(negedge clk);
    p2_up = 1'b1;
    wait_clks(3);
    p2_up = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (dut.u_db_p2_up.level !== 1'b0)
        $display("FAIL glitch_level_clk%0d: got %b expected 0", k, dut.u_db_p2_up.level);
      else n_pass++;
    end
    tick();
    n_checks++;
    if (paddle2_y !== 10'd191)
      $display("FAIL glitch_no_move: got %0d expected 191", paddle2_y);
    else n_pass++;
  endtask

  task automatic test_inactive_gameover();
    p2_up = 1'b1;
    wait_clks(8);
    repeat (50) tick();
    n_checks++;
    if (paddle1_y !== 10'd383 || paddle2_y !== 10'd0)
      $display("FAIL setup_edges: got p1=%0d p2=%0d expected 383/0", paddle1_y, paddle2_y);
    else n_pass++;
    game_active = 1'b0;
    p2_up = 1'b0;
    p1_up = 1'b1; p2_down = 1'b1;
    wait_clks(8);
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++;
      if (paddle1_y !== 10'd383 || paddle2_y !== 10'd0)
        $display("FAIL inactive_hold%0d: got p1=%0d p2=%0d expected 383/0", k, paddle1_y, paddle2_y);
      else n_pass++;
    end
    game_over = 1'b1;
    wait_clks(2);
    n_checks++;
    if (paddle1_y !== 10'd383 || paddle2_y !== 10'd0)
      $display("FAIL game_over_waits_tick: got p1=%0d p2=%0d expected 383/0", paddle1_y, paddle2_y);
    else n_pass++;
    tick();
    n_checks++;
    if (paddle1_y !== 10'd191 || paddle2_y !== 10'd191)
      $display("FAIL game_over_center: got p1=%0d p2=%0d expected 191/191", paddle1_y, paddle2_y);
    else n_pass++;
    game_over = 1'b0;
    p1_up = 1'b0; p2_down = 1'b0;
    wait_clks(8);
  endtask

  task automatic test_ai();
    int exp;
    game_active = 1'b1;
    ai_enable = 1'b1;
    ball_y = 10'd25;
    p2_down = 1'b1;  // must be ignored while the AI drives paddle 2
    wait_clks(8);
    for (int k = 1; k <= 70; k++) begin
      tick();
      exp = (191 - 3 * k >= 2) ? 191 - 3 * k : 2;
      n_checks++;
      if (paddle2_y !== 10'(exp) || paddle1_y !== 10'd191)
        $display("FAIL ai_down_tick%0d: got p2=%0d p1=%0d expected %0d/191", k, paddle2_y, paddle1_y, exp);
      else n_pass++;
    end
    ball_y = 10'd479;
    wait_clks(2);
    for (int k = 1; k <= 56; k++) begin
      tick();
      exp = 2 + 3 * k;
      n_checks++;
      if (paddle2_y !== 10'(exp))
        $display("FAIL ai_up_tick%0d: got %0d expected %0d", k, paddle2_y, exp);
      else n_pass++;
    end
    ball_y = 10'd229;
    wait_clks(2);
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_checks++;
      if (paddle2_y !== 10'd170)
        $display("FAIL ai_deadband%0d: got %0d expected 170", k, paddle2_y);
      else n_pass++;
    end
    ai_enable = 1'b0;
    tick();
    n_checks++;
    if (paddle2_y !== 10'd174)
      $display("FAIL ai_off_manual: got %0d expected 174", paddle2_y);
    else n_pass++;
    p2_down = 1'b0;
    wait_clks(8);
  endtask

  task automatic test_reset_mid();
    p1_down = 1'b1;
    wait_clks(8);
    tick();
    tick();
    n_checks++;
    if (paddle1_y !== 10'd199)
      $display("FAIL mid_setup: got %0d expected 199", paddle1_y);
    else n_pass++;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (paddle1_y !== 10'd191 || paddle2_y !== 10'd191)
      $display("FAIL reset_async: got p1=%0d p2=%0d expected 191/191", paddle1_y, paddle2_y);
    else n_pass++;
    n_checks++;
    if (dut.u_db_p1_down.level !== 1'b0)
      $display("FAIL reset_async_level: got %b expected 0", dut.u_db_p1_down.level);
    else n_pass++;
    wait_clks(2);
    reset_n = 1'b1;
    // Debounce restarts after reset, so a tick right away must not move.
    tick();
    n_checks++;
    if (paddle1_y !== 10'd191)
      $display("FAIL post_reset_tick: got %0d expected 191", paddle1_y);
    else n_pass++;
    p1_down = 1'b0;
    wait_clks(4);
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    refresh_tick = 1'b0;
    game_active = 1'b0;
    game_over = 1'b0;
    ai_enable = 1'b0;
    ball_y = 10'd240;
    p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0;
    test_reset();
    test_p1_up();
    test_p1_down_both();
    test_glitch();
    test_inactive_gameover();
    test_ai();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
